// File: rtl/slice_sequencer.sv
// Slice job sequencer: debounces start/pause keys, runs an IDLE/RUN/PAUSED/DONE
// FSM and counts completed slices until the job is complete.
module slice_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_SLICES      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n_i,
  input  logic       key_pause_n_i,
  input  logic       slice_done_i,
  output logic       start_o,
  output logic       pause_o,
  output logic       finish_o,
  output logic [4:0] slice_num_o,
  output logic       run_o,
  output logic [1:0] state_dbg_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] SLICE_PRE = 5'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit 0 carries the start key, bit 1 the pause key.
  logic [1:0]    key_raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    deb_prev_q, deb_prev_d;
  logic [1:0]    evt_q, evt_d;
  logic [CW-1:0] stab_q [2];
  logic [CW-1:0] stab_d [2];

  state_t        state_q, state_d;
  logic [4:0]    slices_q, slices_d;
  logic          start_q, start_d;
  logic          pause_q, pause_d;
  logic          run_q, run_d;
  logic          finish_q, finish_d;

  assign key_raw = {key_pause_n_i, key_start_n_i};

  // The stability counter runs only while the synchronized level disagrees
  // with the debounced level; any agreement restarts it.
  always_comb begin
    sync1_d    = key_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    evt_d      = deb_prev_q & ~deb_q;
    for (int k = 0; k < 2; k++) begin
      stab_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (stab_q[k] == CNT_LAST) begin
          deb_d[k] = sync2_q[k];
        end else begin
          stab_d[k] = stab_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      deb_q      <= 2'b11;
      deb_prev_q <= 2'b11;
      evt_q      <= 2'b00;
      stab_q[0]  <= '0;
      stab_q[1]  <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      evt_q      <= evt_d;
      stab_q[0]  <= stab_d[0];
      stab_q[1]  <= stab_d[1];
    end
  end

  // A completing slice wins over a same-cycle pause press.
  always_comb begin
    state_d  = state_q;
    slices_d = slices_q;
    start_d  = 1'b0;
    pause_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt_q[0]) begin
          state_d = RUN;
          start_d = 1'b1;
        end
      end
      RUN: begin
        if (slice_done_i) begin
          slices_d = slices_q + 1'b1;
        end
        if (slice_done_i && (slices_q == SLICE_PRE)) begin
          state_d = DONE;
        end else if (evt_q[1]) begin
          state_d = PAUSED;
          pause_d = 1'b1;
        end
      end
      PAUSED: begin
        if (evt_q[1]) begin
          state_d = RUN;
          pause_d = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    run_d    = (state_d == RUN);
    finish_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      slices_q <= 5'd0;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
      run_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slices_q <= slices_d;
      start_q  <= start_d;
      pause_q  <= pause_d;
      run_q    <= run_d;
      finish_q <= finish_d;
    end
  end

  assign start_o     = start_q;
  assign pause_o     = pause_q;
  assign finish_o    = finish_q;
  assign run_o       = run_q;
  assign slice_num_o = slices_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// Directed bench for slice_sequencer with DEBOUNCE_CYCLES=4, NUM_SLICES=3:
// a vector table for the start-press latency plus hand-written sequences.
module tb_slice_sequencer;

  localparam int DB = 4;
  localparam int NS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ks, kp, sd;
  logic       start_o, pause_o, finish_o, run_o;
  logic [4:0] slice_num_o;
  logic [1:0] state_dbg_o;

  int n_cmp = 0;
  int n_bad = 0;

  slice_sequencer #(.DEBOUNCE_CYCLES(DB), .NUM_SLICES(NS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_start_n_i(ks),
    .key_pause_n_i(kp),
    .slice_done_i (sd),
    .start_o      (start_o),
    .pause_o      (pause_o),
    .finish_o     (finish_o),
    .slice_num_o  (slice_num_o),
    .run_o        (run_o),
    .state_dbg_o  (state_dbg_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ks;
    logic       kp;
    logic       sd;
    logic       st;
    logic       pa;
    logic       fi;
    logic       ru;
    logic [4:0] num;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic st, input logic pa, input logic fi,
                         input logic ru, input logic [4:0] num);
    chk({tag, ".start_o"},  32'(start_o),     32'(st));
    chk({tag, ".pause_o"},  32'(pause_o),     32'(pa));
    chk({tag, ".finish_o"}, 32'(finish_o),    32'(fi));
    chk({tag, ".run_o"},    32'(run_o),       32'(ru));
    chk({tag, ".slice_num"}, 32'(slice_num_o), 32'(num));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_slice;
    sd = 1'b1;
    tick();
    sd = 1'b0;
    tick();
  endtask

  // Holds one key low for 12 edges then releases it for 12 more, counting
  // output pulses; edge 0 is the first edge that samples the key low.
  // With coincide set, slice_done_i is high on edge 7, where the press lands.
  task automatic press(input bit pause_key, input bit coincide,
                       output int sp, output int pp, output int first_edge);
    sp = 0;
    pp = 0;
    first_edge = -1;
    if (pause_key) kp = 1'b0;
    else ks = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (start_o) sp++;
      if (pause_o) pp++;
      if ((start_o || pause_o) && first_edge < 0) first_edge = i;
      if (coincide) sd = (i == 6);
      if (i == 11) begin
        ks = 1'b1;
        kp = 1'b1;
      end
    end
    sd = 1'b0;
  endtask

  int sp, pp, fe, cnt;

  initial begin
    ks = 1'b1;
    kp = 1'b1;
    sd = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("reset.state", 32'(state_dbg_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Start key held low from edge 0: start_o only at edge 7; a slice in IDLE is ignored.
    for (int i = 0; i < 9; i++) begin
      tbl[i] = '{ks: 1'b0, kp: 1'b1, sd: (i == 3), st: (i == 7), pa: 1'b0,
                 fi: 1'b0, ru: (i >= 7), num: 5'd0};
    end
    for (int i = 0; i < 9; i++) begin
      ks = tbl[i].ks;
      kp = tbl[i].kp;
      sd = tbl[i].sd;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pa, tbl[i].fi, tbl[i].ru, tbl[i].num);
    end
    sd = 1'b0;

    // Start release produces no event.
    ks = 1'b1;
    cnt = 0;
    repeat (12) begin
      tick();
      if (start_o) cnt++;
    end
    chk("release.start_pulses", 32'(cnt), 32'd0);

    // Three-cycle pause glitch is rejected.
    kp = 1'b0;
    cnt = 0;
    repeat (3) tick();
    kp = 1'b1;
    repeat (12) begin
      tick();
      if (pause_o) cnt++;
    end
    chk("glitch.pause_pulses", 32'(cnt), 32'd0);
    chk("glitch.state", 32'(state_dbg_o), 32'd1);
    chk("glitch.run", 32'(run_o), 32'd1);

    pulse_slice();
    pulse_slice();
    chk("run2.slice_num", 32'(slice_num_o), 32'd2);

    press(1'b1, 1'b0, sp, pp, fe);
    chk("pause1.pulses", 32'(pp), 32'd1);
    chk("pause1.edge", 32'(fe), 32'd7);
    chk("pause1.start_pulses", 32'(sp), 32'd0);
    chk("pause1.state", 32'(state_dbg_o), 32'd2);
    chk("pause1.run", 32'(run_o), 32'd0);

    pulse_slice();
    pulse_slice();
    chk("paused.slice_num", 32'(slice_num_o), 32'd2);

    press(1'b1, 1'b0, sp, pp, fe);
    chk("pause2.pulses", 32'(pp), 32'd1);
    chk("pause2.state", 32'(state_dbg_o), 32'd1);
    chk_all("resumed", 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);

    // Final slice together with a pause press: DONE wins, no pause pulse.
    press(1'b1, 1'b1, sp, pp, fe);
    chk("final.pause_pulses", 32'(pp), 32'd0);
    chk("final.state", 32'(state_dbg_o), 32'd3);
    chk_all("final", 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);

    press(1'b0, 1'b0, sp, pp, fe);
    chk("done.start_pulses", 32'(sp), 32'd0);
    press(1'b1, 1'b0, sp, pp, fe);
    chk("done.pause_pulses", 32'(pp), 32'd0);
    pulse_slice();
    chk_all("done.hold", 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
    chk("done.state", 32'(state_dbg_o), 32'd3);

    // Asynchronous reset mid-RUN at slice 1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    press(1'b0, 1'b0, sp, pp, fe);
    chk("restart.start_pulses", 32'(sp), 32'd1);
    chk("restart.edge", 32'(fe), 32'd7);
    pulse_slice();
    chk("restart.slice_num", 32'(slice_num_o), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("async_rst.state", 32'(state_dbg_o), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("post_rst.state", 32'(state_dbg_o), 32'd0);
    chk("post_rst.run", 32'(run_o), 32'd0);

    // Slice and pause coincide below the limit: both take effect.
    press(1'b0, 1'b0, sp, pp, fe);
    chk("c.start_pulses", 32'(sp), 32'd1);
    pulse_slice();
    press(1'b1, 1'b1, sp, pp, fe);
    chk("c.pause_pulses", 32'(pp), 32'd1);
    chk("c.pause_edge", 32'(fe), 32'd7);
    chk("c.slice_num", 32'(slice_num_o), 32'd2);
    chk("c.state", 32'(state_dbg_o), 32'd2);
    chk("c.finish", 32'(finish_o), 32'd0);
    press(1'b0, 1'b0, sp, pp, fe);
    chk("c.paused_start_pulses", 32'(sp), 32'd0);
    chk("c.paused_state", 32'(state_dbg_o), 32'd2);

    // Start key held through reset release counts as a new press.
    ks = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    press(1'b0, 1'b0, sp, pp, fe);
    chk("held.start_pulses", 32'(sp), 32'd1);
    chk("held.edge", 32'(fe), 32'd7);
    chk("held.state", 32'(state_dbg_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
